pb_conditioner: RTL and testbench

- Conditions the two raw player push-buttons before they reach the push-button latch of the tug-of-war game.
- Per button: 2-flop synchronizer, counter-based debouncer, rising-edge one-shot.
- Drives the latch's pbl/pbr inputs with clean single-cycle press pulses.
- An arm input suppresses presses outside the play window. A button already held when arming occurs must be released and re-pressed before it counts.

---
 rtl/pb_conditioner_if.sv | 27 ++
 rtl/pb_conditioner.sv | 103 ++++++++++
 tb/tb_pb_conditioner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pb_conditioner_if.sv
// Bundles the push-button conditioner's button, arm and pulse signals.
//   pbl_raw/pbr_raw : raw asynchronous button levels (active-high)
//   arm             : 1 = presses may generate pulses
//   pbl/pbr         : one-clock press pulses toward the push-button latch
//   pbl_lvl/pbr_lvl : debounced button levels
//   both            : pbl and pbr pulsed in the same cycle
// The master side drives buttons/arm; the slave side is the conditioner.
interface pb_conditioner_if;
  logic pbl_raw;
  logic pbr_raw;
  logic arm;
  logic pbl;
  logic pbr;
  logic pbl_lvl;
  logic pbr_lvl;
  logic both;

  modport master (
    output pbl_raw, pbr_raw, arm,
    input  pbl, pbr, pbl_lvl, pbr_lvl, both
  );

  modport slave (
    input  pbl_raw, pbr_raw, arm,
    output pbl, pbr, pbl_lvl, pbr_lvl, both
  );
endinterface

// File: rtl/pb_conditioner.sv
// Push-button conditioner for the tug-of-war game. Each of the two buttons
// goes through a 2-flop synchronizer, a counter debouncer and a rising-edge
// one-shot. Presses are suppressed while arm is low, and a button already
// held when play is armed must be released and pressed again to count.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   pb   : pb_conditioner_if.slave (raw buttons, arm, pulses, levels, both)
// Channel index 0 is the left button, 1 is the right button.
module pb_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input logic         clk,
  input logic         rst,
  pb_conditioner_if.slave pb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       raw;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       need_rel_q, need_rel_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             both_q, both_d;
  logic             arm_q, arm_d;

  assign raw = {pb.pbr_raw, pb.pbl_raw};

  // NOTE: every always_comb output starts from a default so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    s1_d       = raw;
    s2_d       = s1_q;
    lvl_d      = lvl_q;
    need_rel_d = need_rel_q;
    pulse_d    = '0;
    cnt_d      = cnt_q;
    arm_d      = pb.arm;

    for (int c = 0; c < 2; c++) begin
      // Any sample agreeing with the debounced level restarts the count, so
      // the counter never exceeds CNT_MAX and cannot wrap.
      if (s2_q[c] == lvl_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_MAX) begin
        lvl_d[c] = s2_q[c];
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_ONE;
      end

      pulse_d[c] = ~lvl_q[c] & lvl_d[c] & pb.arm & ~need_rel_q[c];

      // A level that is high while disarmed, or high at the moment arm
      // rises, was not pressed inside the play window: lock it out until
      // the button is seen released.
      if (!lvl_q[c]) begin
        need_rel_d[c] = 1'b0;
      end else if (!pb.arm || !arm_q) begin
        need_rel_d[c] = 1'b1;
      end
    end

    both_d = &pulse_d;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      lvl_q      <= '0;
      need_rel_q <= '0;
      pulse_q    <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      both_q     <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_q      <= lvl_d;
      need_rel_q <= need_rel_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      both_q     <= both_d;
      arm_q      <= arm_d;
    end
  end

  assign pb.pbl     = pulse_q[0];
  assign pb.pbr     = pulse_q[1];
  assign pb.pbl_lvl = lvl_q[0];
  assign pb.pbr_lvl = lvl_q[1];
  assign pb.both    = both_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner (DEB_CYCLES=4). A behavioural model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_pb_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  pb_conditioner_if pb ();

  pb_conditioner #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .pb  (pb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Synchronizer: raw_s at an edge is the raw value sampled two edges ago.
  // Debounce: the level flips once the last DEB synchronized samples, all
  // taken since the previous flip or reset, disagree with it.
  logic           m_d1 [2];
  logic           m_d2 [2];
  logic [DEB-1:0] m_hist [2];
  int             m_nvalid [2];
  logic           m_lvl [2];
  logic           m_nr [2];
  logic           m_pulse [2];
  logic           m_both;
  logic           m_armp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_d1[c] = 0; m_d2[c] = 0; m_hist[c] = '0; m_nvalid[c] = 0;
        m_lvl[c] = 0; m_nr[c] = 0; m_pulse[c] = 0;
      end
      m_both = 0;
      m_armp = 0;
    end else begin
      logic raw [2];
      logic p [2];
      raw[0] = pb.pbl_raw;
      raw[1] = pb.pbr_raw;
      for (int c = 0; c < 2; c++) begin
        logic rs, old, flip;
        rs = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = raw[c];
        m_hist[c] = {m_hist[c][DEB-2:0], rs};
        if (m_nvalid[c] < DEB) m_nvalid[c]++;
        old  = m_lvl[c];
        flip = (m_nvalid[c] == DEB) && (m_hist[c] == (old ? {DEB{1'b0}} : {DEB{1'b1}}));
        p[c] = flip && !old && pb.arm && !m_nr[c];
        if (!old) m_nr[c] = 0;
        else if (!pb.arm || !m_armp) m_nr[c] = 1;
        if (flip) begin
          m_lvl[c] = !old;
          m_nvalid[c] = 0;
        end
      end
      m_pulse[0] = p[0];
      m_pulse[1] = p[1];
      m_both = p[0] & p[1];
      m_armp = pb.arm;
    end
  end

  // ---------------- per-cycle compare + pulse counters ----------------
  bit cmp_en = 0;
  int cnt_pbl = 0;
  int cnt_pbr = 0;
  int cnt_both = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pbl",     pb.pbl,     m_pulse[0]);
      check("pbr",     pb.pbr,     m_pulse[1]);
      check("pbl_lvl", pb.pbl_lvl, m_lvl[0]);
      check("pbr_lvl", pb.pbr_lvl, m_lvl[1]);
      check("both",    pb.both,    m_both);
    end
    if (pb.pbl === 1'b1) cnt_pbl++;
    if (pb.pbr === 1'b1) cnt_pbr++;
    if (pb.both === 1'b1) cnt_both++;
  end

  // Advance one edge; inputs are changed and literal checks made #1 after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    cnt_pbl = 0; cnt_pbr = 0; cnt_both = 0;
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  initial begin
    pb.pbl_raw = 0;
    pb.pbr_raw = 0;
    pb.arm     = 1;
    #2;
    cmp_en = 1;
    check("reset_pbl_lvl", pb.pbl_lvl, 1'b0);
    check("reset_pbl",     pb.pbl,     1'b0);
    tick(3);
    rst = 1;
    tick(1);
    check("first_edge_pbl", pb.pbl, 1'b0);
    check("first_edge_both", pb.both, 1'b0);
    tick(4);

    // Clean press: raw high before edge 0, level + pulse after edge 5.
    clear_counts();
    pb.pbl_raw = 1;
    tick(5);                                   // edges 0..4
    check("clean_lvl_e4", pb.pbl_lvl, 1'b0);
    tick(1);                                   // edge 5
    check("clean_lvl_e5", pb.pbl_lvl, 1'b1);
    check("clean_pbl_e5", pb.pbl, 1'b1);
    check("clean_pbr_e5", pb.pbr, 1'b0);
    check("clean_both_e5", pb.both, 1'b0);
    tick(1);                                   // edge 6
    check("clean_pbl_e6", pb.pbl, 1'b0);
    pb.pbl_raw = 0;                            // release: no pulse
    tick(10);
    check("release_lvl", pb.pbl_lvl, 1'b0);
    check_cnt("clean_pulses", cnt_pbl, 1);

    // Bounce on right button, then final rise sampled at edge F.
    clear_counts();
    pb.pbr_raw = 1; tick(1);
    pb.pbr_raw = 0; tick(1);
    pb.pbr_raw = 1; tick(1);
    pb.pbr_raw = 0; tick(1);
    pb.pbr_raw = 1;
    tick(5);                                   // edges F..F+4
    check("bounce_pbr_e4", pb.pbr, 1'b0);
    tick(1);                                   // edge F+5
    check("bounce_pbr_e5", pb.pbr, 1'b1);
    tick(6);
    check_cnt("bounce_pulses", cnt_pbr, 1);
    pb.pbr_raw = 0;
    tick(10);

    // Disarmed hold, arm while held, release and re-press.
    clear_counts();
    pb.arm = 0;
    pb.pbl_raw = 1;
    tick(10);
    pb.arm = 1;
    tick(8);
    check_cnt("disarmed_hold_pulses", cnt_pbl, 0);
    pb.pbl_raw = 0;
    tick(10);
    pb.pbl_raw = 1;
    tick(10);
    check_cnt("rearm_pulses", cnt_pbl, 1);
    pb.pbl_raw = 0;
    tick(10);

    // Simultaneous press.
    clear_counts();
    pb.pbl_raw = 1; pb.pbr_raw = 1;
    tick(6);
    check("simul_pbl", pb.pbl, 1'b1);
    check("simul_pbr", pb.pbr, 1'b1);
    check("simul_both", pb.both, 1'b1);
    tick(1);
    check("simul_both_off", pb.both, 1'b0);
    pb.pbl_raw = 0; pb.pbr_raw = 0;
    tick(10);
    check_cnt("simul_both_count", cnt_both, 1);

    // Reset mid-count with left level high; release with left held.
    pb.pbl_raw = 1;
    tick(8);
    pb.pbr_raw = 1;
    tick(3);
    #2;
    rst = 0;
    #1;
    check("async_rst_pbl_lvl", pb.pbl_lvl, 1'b0);
    check("async_rst_pbr_lvl", pb.pbr_lvl, 1'b0);
    pb.pbr_raw = 0;
    tick(2);
    rst = 1;
    clear_counts();
    tick(5);                                   // edges 0..4 after release
    check("post_rst_pbl_e4", pb.pbl, 1'b0);
    tick(1);                                   // edge 5
    check("post_rst_pbl_e5", pb.pbl, 1'b1);
    pb.pbl_raw = 0;
    tick(10);

    // Randomized phase: each button holds a random level for 1..12 cycles,
    // arm flips occasionally, and reset is pulsed rarely.
    begin
      int hold_l = 0, hold_r = 0;
      for (int i = 0; i < 4000; i++) begin
        if (hold_l == 0) begin pb.pbl_raw = $urandom_range(0, 1); hold_l = $urandom_range(1, 12); end
        if (hold_r == 0) begin pb.pbr_raw = $urandom_range(0, 1); hold_r = $urandom_range(1, 12); end
        hold_l--; hold_r--;
        if ($urandom_range(0, 39) == 0) pb.arm = ~pb.arm;
        if ($urandom_range(0, 499) == 0) begin
          #2; rst = 0; tick(1); rst = 1;
        end else begin
          tick(1);
        end
      end
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
